// File: rtl/cw_clock_pkg.sv
// cw_clock_pkg: mode encodings, digit limits and BCD
// increment helpers shared by the time-of-day path.
package cw_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10,
    MODE_BAD      = 2'b11
  } mode_e;

  localparam logic [3:0] UNIT_MAX   = 4'd9;
  localparam logic [2:0] TENS_MAX   = 3'd5;
  localparam int         HOUR_LIMIT = 23;

  typedef struct packed {
    logic [1:0] t;
    logic [3:0] u;
  } hour_t;

  typedef struct packed {
    logic [2:0] t;
    logic [3:0] u;
  } bcd60_t;

  localparam bcd60_t LAST60 = '{t: TENS_MAX, u: UNIT_MAX};

  function automatic bcd60_t inc60(input bcd60_t v);
    bcd60_t r;
    r = v;
    if (v.u != UNIT_MAX) begin
      r.u = v.u + 4'd1;
    end else if (v.t != TENS_MAX) begin
      r.t = v.t + 3'd1;
      r.u = 4'd0;
    end else begin
      r = '0;
    end
    return r;
  endfunction

  function automatic logic hour_is_max(
    input hour_t v,
    input int    max
  );
    return (int'(v.t) == max / 10) &&
           (int'(v.u) == max % 10);
  endfunction

  function automatic hour_t inc_hour(
    input hour_t v,
    input int    max
  );
    hour_t r;
    r = v;
    if (hour_is_max(v, max)) begin
      r = '0;
    end else if (v.u == UNIT_MAX) begin
      r.t = v.t + 2'd1;
      r.u = 4'd0;
    end else begin
      r.u = v.u + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cw_edge_sync.sv
// cw_edge_sync: multi-flop synchroniser with a registered
// rising-edge pulse, for slow asynchronous level inputs.
module cw_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Async,
  output logic o_Rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // o_Rise is registered so the consumer sees a clean
  // flop output rather than gating logic.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      o_Rise <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_Async};
      last_q <= sync_q[STAGES-1];
      o_Rise <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/cw_time_keeper.sv
// cw_time_keeper: BCD hh:mm:ss counter advanced by the
// synchronised 1 Hz tick, with a hour/minute set mode.
module cw_time_keeper
  import cw_clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_MAX    = HOUR_LIMIT
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Tick,
  input  logic       i_Set,
  input  logic       i_Inc,
  output logic [1:0] o_Hour_T,
  output logic [3:0] o_Hour_U,
  output logic [2:0] o_Min_T,
  output logic [3:0] o_Min_U,
  output logic [2:0] o_Sec_T,
  output logic [3:0] o_Sec_U,
  output logic [1:0] o_Mode,
  output logic       o_Sec_Pulse,
  output logic       o_Day_Wrap
);

  logic   tick_en;
  mode_e  mode_q, mode_d;
  hour_t  hour_q, hour_d;
  bcd60_t min_q, min_d;
  bcd60_t sec_q, sec_d;
  logic   pulse_q, pulse_d;
  logic   wrap_q, wrap_d;

  cw_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_Tick),
    .o_Rise  (tick_en)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mode_q  <= MODE_RUN;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      pulse_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    wrap_d  = 1'b0;
    unique case (mode_q)
      MODE_RUN: begin
        if (tick_en) begin
          pulse_d = 1'b1;
          sec_d   = inc60(sec_q);
          if (sec_q == LAST60) begin
            min_d = inc60(min_q);
            if (min_q == LAST60) begin
              hour_d = inc_hour(hour_q, HOUR_MAX);
              wrap_d = hour_is_max(hour_q, HOUR_MAX);
            end
          end
        end
        if (i_Set) mode_d = MODE_SET_HOUR;
      end
      MODE_SET_HOUR: begin
        if (i_Set) begin
          mode_d = MODE_SET_MIN;
        end else if (i_Inc) begin
          hour_d = inc_hour(hour_q, HOUR_MAX);
        end
      end
      MODE_SET_MIN: begin
        // Leaving set mode restarts the minute cleanly.
        if (i_Set) begin
          mode_d = MODE_RUN;
          sec_d  = '0;
        end else if (i_Inc) begin
          min_d = inc60(min_q);
        end
      end
      MODE_BAD: begin
        mode_d = MODE_RUN;
      end
    endcase
  end

  assign o_Hour_T    = hour_q.t;
  assign o_Hour_U    = hour_q.u;
  assign o_Min_T     = min_q.t;
  assign o_Min_U     = min_q.u;
  assign o_Sec_T     = sec_q.t;
  assign o_Sec_U     = sec_q.u;
  assign o_Mode      = mode_q;
  assign o_Sec_Pulse = pulse_q;
  assign o_Day_Wrap  = wrap_q;

endmodule

// File: tb/tb_cw_time_keeper.sv
// tb_cw_time_keeper: randomized scoreboard bench against a
// seconds-of-day reference model.
module tb_cw_time_keeper;

  logic       i_Clk   = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Tick  = 1'b0;
  logic       i_Set   = 1'b0;
  logic       i_Inc   = 1'b0;
  logic [1:0] o_Hour_T;
  logic [3:0] o_Hour_U;
  logic [2:0] o_Min_T;
  logic [3:0] o_Min_U;
  logic [2:0] o_Sec_T;
  logic [3:0] o_Sec_U;
  logic [1:0] o_Mode;
  logic       o_Sec_Pulse;
  logic       o_Day_Wrap;

  cw_time_keeper #(
    .SYNC_STAGES (2),
    .HOUR_MAX    (23)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Tick      (i_Tick),
    .i_Set       (i_Set),
    .i_Inc       (i_Inc),
    .o_Hour_T    (o_Hour_T),
    .o_Hour_U    (o_Hour_U),
    .o_Min_T     (o_Min_T),
    .o_Min_U     (o_Min_U),
    .o_Sec_T     (o_Sec_T),
    .o_Sec_U     (o_Sec_U),
    .o_Mode      (o_Mode),
    .o_Sec_Pulse (o_Sec_Pulse),
    .o_Day_Wrap  (o_Day_Wrap)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int due;
    int tod;
    int mode;
    bit p;
    bit w;
  } exp_t;

  exp_t q[$];

  // reference model: seconds of day plus mode 0/1/2
  int tod = 0;
  int mode = 0;
  int last_tod = 0;
  int last_mode = 0;

  function automatic exp_t step(
    input bit tk, input bit st, input bit inc, input int due
  );
    exp_t e;
    int h, m;
    e.p = 1'b0;
    e.w = 1'b0;
    if (tk && mode == 0) begin
      tod = (tod + 1) % 86400;
      e.p = 1'b1;
      e.w = (tod == 0);
    end
    if (st) begin
      if (mode == 2) tod = tod - tod % 60;
      mode = (mode + 1) % 3;
    end else if (inc && mode == 1) begin
      h = (tod / 3600 + 1) % 24;
      tod = h * 3600 + tod % 3600;
    end else if (inc && mode == 2) begin
      m = (tod / 60 % 60 + 1) % 60;
      tod = tod / 3600 * 3600 + m * 60 + tod % 60;
    end
    e.due  = due;
    e.tod  = tod;
    e.mode = mode;
    return e;
  endfunction

  function automatic int dut_tod();
    int h, m, s;
    h = int'(o_Hour_T) * 10 + int'(o_Hour_U);
    m = int'(o_Min_T) * 10 + int'(o_Min_U);
    s = int'(o_Sec_T) * 10 + int'(o_Sec_U);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic void check(
    input string nm, input int act, input int exp
  );
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // monitor: pop expectations as their due cycle arrives
  always @(negedge i_Clk) begin
    exp_t e;
    if (i_Rst_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missed_update: due %0d, now %0d",
                 q[0].due, cyc);
        q.delete(0);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("time_sec_of_day", dut_tod(), e.tod);
        check("mode", int'(o_Mode), e.mode);
        check("sec_pulse", int'(o_Sec_Pulse), int'(e.p));
        check("day_wrap", int'(o_Day_Wrap), int'(e.w));
        last_tod  = e.tod;
        last_mode = e.mode;
      end else begin
        check("idle_pulses",
              int'({o_Sec_Pulse, o_Day_Wrap}), 0);
        check("idle_time", dut_tod(), last_tod);
        check("idle_mode", int'(o_Mode), last_mode);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  task automatic pulse(input bit st, input bit inc);
    i_Set = st;
    i_Inc = inc;
    q.push_back(step(1'b0, st, inc, cyc + 1));
    @(posedge i_Clk);
    #1;
    i_Set = 1'b0;
    i_Inc = 1'b0;
  endtask

  // one full i_Tick period; with_set lands i_Set on the
  // same edge where the tick takes effect
  task automatic tick(input bit with_set);
    int n, hi, lo;
    n  = cyc;
    hi = $urandom_range(3, 5);
    lo = $urandom_range(2, 4);
    i_Tick = 1'b1;
    q.push_back(step(1'b1, with_set, 1'b0, n + 4));
    for (int i = 0; i < hi + lo; i++) begin
      if (i == hi) i_Tick = 1'b0;
      i_Set = with_set && (i == 3);
      @(posedge i_Clk);
      #1;
    end
    i_Set = 1'b0;
  endtask

  task automatic preload(input int h, input int m,
                         input bit stay);
    pulse(1'b1, 1'b0);
    repeat ((h - tod / 3600 + 24) % 24) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat ((m - tod / 60 % 60 + 60) % 60) pulse(1'b0, 1'b1);
    if (!stay) pulse(1'b1, 1'b0);
  endtask

  int r;

  initial begin
    @(posedge i_Clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      i_Tick = i[1];
      @(posedge i_Clk);
      #1;
      check("reset_time", dut_tod(), 0);
      check("reset_mode", int'(o_Mode), 0);
      check("reset_pulses",
            int'({o_Sec_Pulse, o_Day_Wrap}), 0);
    end
    i_Tick = 1'b0;
    idle(3);
    i_Rst_n = 1'b1;
    idle(3);

    tick(1'b0);

    pulse(1'b1, 1'b0);
    repeat (25) pulse(1'b0, 1'b1);
    tick(1'b0);
    pulse(1'b1, 1'b0);
    repeat (61) pulse(1'b0, 1'b1);
    tick(1'b0);
    pulse(1'b1, 1'b0);

    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);

    preload(23, 59, 1'b0);
    repeat (60) tick(1'b0);
    preload(9, 59, 1'b0);
    repeat (60) tick(1'b0);
    preload(19, 59, 1'b0);
    repeat (60) tick(1'b0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) tick(1'b0);
      else if (r == 6) tick(1'b1);
      else if (r == 7) pulse(1'b1, 1'b0);
      else if (r == 8) pulse(1'b0, 1'b1);
      else pulse(1'b1, 1'b1);
      idle($urandom_range(0, 2));
    end
    while (mode != 0) pulse(1'b1, 1'b0);

    preload(12, 34, 1'b1);
    #5;
    i_Rst_n = 1'b0;
    #2;
    check("async_rst_time", dut_tod(), 0);
    check("async_rst_mode", int'(o_Mode), 0);
    check("async_rst_pulses",
          int'({o_Sec_Pulse, o_Day_Wrap}), 0);
    q.delete();
    tod = 0;
    mode = 0;
    last_tod = 0;
    last_mode = 0;
    @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;
    idle(2);

    repeat (5) tick(1'b0);
    tick(1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    tick(1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0",
               q.size());
    end
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cw_time_keeper.md
# cw_time_keeper

Time-of-day counter that consumes the divided 1 Hz square wave from the clock divider stage and maintains hours, minutes and seconds as BCD digits for the display driver. The divider output is treated as a data signal: it is synchronised into `i_Clk`, edge-detected into a one-cycle tick, and used as a count enable. No derived clocks. A three-state set mode lets the user adjust hours and minutes with two pre-debounced pulse inputs.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `i_Tick` synchroniser (≥2).
- `HOUR_MAX`, 23: last hour value before wrap (24-hour format only).
- `i_Clk`  in  1  system clock; all state on rising edge.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_Tick`  in  1  divided clock level from the divider (50% duty, 1 Hz); asynchronous to `i_Clk` for design purposes.
- `i_Set`  in  1  one-cycle pulse; advances set mode.
- `i_Inc`  in  1  one-cycle pulse; increments the field selected in set mode.
- `o_Hour_T`  out  2  hours tens (0–2).
- `o_Hour_U`  out  4  hours units (0–9).
- `o_Min_T`  out  3  minutes tens (0–5).
- `o_Min_U`  out  4  minutes units (0–9).
- `o_Sec_T`  out  3  seconds tens (0–5).
- `o_Sec_U`  out  4  seconds units (0–9).
- `o_Mode`  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 unused).
- `o_Sec_Pulse`  out  1  one-cycle pulse on every seconds advance.
- `o_Day_Wrap`  out  1  one-cycle pulse on 23:59:59 → 00:00:00.

## Operation
- Reset (async assert, sync release): all digits 0, `o_Mode`=RUN, pulses 0, synchroniser and edge register cleared to 0.
- Tick path: `i_Tick` → SYNC_STAGES flops → one extra register; `tick_en` = last sync stage & ~extra register (rising edge only).
- RUN: on `tick_en`, seconds +1 with BCD carry chain: Sec_U 9→0 carries to Sec_T; Sec_T 5→0 carries to Min_U; minutes likewise; hour 23→00. Hours are held BCD: 09→10, 19→20, 23→00. `o_Sec_Pulse` is 1 for the same cycle as the update. `o_Day_Wrap` is 1 only for the 23:59:59 → 00:00:00 update.
- FSM: RUN --`i_Set`--> SET_HOUR --`i_Set`--> SET_MIN --`i_Set`--> RUN. Encoding 11 is unreachable; if it is entered, the next cycle goes to RUN.
- SET_HOUR: `i_Inc` → hour +1, 23→00, no other field changes.
- SET_MIN: `i_Inc` → minute +1, 59→00, no carry into hours.
- In both set states, `tick_en` is ignored: time frozen, no `o_Sec_Pulse`.
- SET_MIN → RUN transition clears seconds to 00.
- Simultaneous events:
  - `i_Set` and `i_Inc` in the same cycle: `i_Set` wins and `i_Inc` is dropped.
  - `tick_en` and `i_Set` in RUN: the tick is applied and the state moves to SET_HOUR in the same edge.
  - `tick_en` and `i_Set` in SET_MIN: seconds clear wins. Tick is discarded.
- Reset mid-count or mid-set: immediate return to 00:00:00 RUN.

## Timing
- `i_Tick` first sampled high at edge k: with SYNC_STAGES=2, `tick_en` is high between edges k+2 and k+3, and digits and `o_Sec_Pulse` update at edge k+3. Generally, the update is at edge k+SYNC_STAGES+1.
- `i_Set` / `i_Inc` sampled at edge k → `o_Mode` and digits change at edge k. Single-cycle response, no internal latency.
- All outputs are registered; no combinational path from inputs to outputs.
- Exactly one advance per `i_Tick` rising edge; falling edges produce nothing.

## Structure
- Shared include `cw_clock_pkg.v` holds:
  - mode encodings `MODE_RUN` / `MODE_SET_HOUR` / `MODE_SET_MIN`
  - digit limits (9, 5, hour limit 23).
- Sub-module `cw_edge_sync`: parameterised synchroniser plus rising-edge detector (ports `i_Clk`, `i_Rst_n`, `i_Async`, `o_Rise`). It is reused for future button inputs.
- Carry chain and FSM stay in `cw_time_keeper`.

## Test plan
- Reset held low with `i_Tick` toggling → all digits 0, `o_Mode`=00, no pulses. Release, then one `i_Tick` rise → 00:00:01 exactly SYNC_STAGES+1 edges after the first high sample.
- Preload via set mode to 23:59, then run 59 ticks → 23:59:59. Next tick → 00:00:00 with `o_Day_Wrap` and `o_Sec_Pulse` each high for 1 cycle.
- Run to 09:59:59 and tick → 10:00:00. Run to 19:59:59 and tick → 20:00:00.
- `i_Set` once, then `i_Inc` ×25 → hour 01. `i_Set`, then `i_Inc` ×61 → min 01 with hour still 01. Ticks during both states cause no change. `i_Set` → RUN with seconds 00.
- `i_Set` and `i_Inc` in the same cycle from RUN → mode SET_HOUR, hour unchanged. `tick_en` coincident with `i_Set` in RUN at 00:00:05 → 00:00:06 and mode SET_HOUR.
- Assert `i_Rst_n` low asynchronously mid-cycle during SET_MIN at 12:34 → outputs 00:00:00 and RUN before the next clock edge.
